// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: default message width, the positive magnitude
// limit, and sign-magnitude <-> two's-complement helpers used by the VN and CN stages.
package ldpc_pkg;

  localparam int unsigned LDPC_MSG_WIDTH = 6;
  localparam int unsigned LDPC_POS_MAX   = (1 << (LDPC_MSG_WIDTH - 1)) - 1;
  localparam int unsigned LDPC_MAX_W     = 16;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } cn_state_e;

  // Width-generic: the message occupies the low w bits, and the caller truncates the result.
  function automatic logic [LDPC_MAX_W-1:0] sm2tc(input logic [LDPC_MAX_W-1:0] sm,
                                                  input int unsigned w);
    logic [LDPC_MAX_W-1:0] mask;
    logic [LDPC_MAX_W-1:0] mag;
    logic [LDPC_MAX_W-1:0] sgn;
    mask = (LDPC_MAX_W'(1) << (w - 1)) - LDPC_MAX_W'(1);
    mag  = sm & mask;
    sgn  = (sm >> (w - 1)) & LDPC_MAX_W'(1);
    return (sgn != '0) ? (~mag + LDPC_MAX_W'(1)) : mag;
  endfunction

  function automatic logic [LDPC_MAX_W-1:0] tc2sm(input logic [LDPC_MAX_W-1:0] tc,
                                                  input int unsigned w);
    logic [LDPC_MAX_W-1:0] mask;
    logic [LDPC_MAX_W-1:0] mag;
    logic [LDPC_MAX_W-1:0] sgn;
    mask = (LDPC_MAX_W'(1) << (w - 1)) - LDPC_MAX_W'(1);
    sgn  = (tc >> (w - 1)) & LDPC_MAX_W'(1);
    mag  = ((sgn != '0) ? (~tc + LDPC_MAX_W'(1)) : tc) & mask;
    return (sgn << (w - 1)) | mag;
  endfunction

endpackage

// File: rtl/cn_min2_update.sv
// Combinational min1/min2/argmin update for one incoming magnitude.
// Strict compares: the first of two equal minima keeps idx1, and the second fills min2.
module cn_min2_update #(
  parameter int unsigned MAG_W = 5,
  parameter int unsigned IDX_W = 5
) (
  input  logic [MAG_W-1:0] i_min1,
  input  logic [MAG_W-1:0] i_min2,
  input  logic [IDX_W-1:0] i_idx1,
  input  logic [MAG_W-1:0] i_mag,
  input  logic [IDX_W-1:0] i_idx,
  output logic [MAG_W-1:0] o_min1,
  output logic [MAG_W-1:0] o_min2,
  output logic [IDX_W-1:0] o_idx1
);

  always_comb begin
    o_min1 = i_min1;
    o_min2 = i_min2;
    o_idx1 = i_idx1;
    if (i_mag < i_min1) begin
      o_min2 = i_min1;
      o_min1 = i_mag;
      o_idx1 = i_idx;
    end else if (i_mag < i_min2) begin
      o_min2 = i_mag;
    end
  end

endmodule

// File: rtl/cn_serial.sv
// Serial offset-min-sum check node: collects one row of sign-magnitude v2c messages,
// then streams two's-complement c2v messages back in input order with the row parity.
module cn_serial
  import ldpc_pkg::*;
#(
  parameter int unsigned MSG_WIDTH = LDPC_MSG_WIDTH,
  parameter int unsigned CN_DEG    = 32,
  parameter int unsigned OFFSET    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_v2c_valid,
  input  logic [MSG_WIDTH-1:0] i_v2c,
  output logic                 o_v2c_ready,
  output logic                 o_c2v_valid,
  output logic [MSG_WIDTH-1:0] o_c2v,
  input  logic                 i_c2v_ready,
  output logic                 o_parity,
  output logic                 o_parity_valid
);

  localparam int unsigned MAG_W = MSG_WIDTH - 1;
  localparam int unsigned IDX_W = (CN_DEG > 1) ? $clog2(CN_DEG) : 1;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(CN_DEG - 1);
  localparam logic [MAG_W-1:0] POS_MAX = '1;
  localparam logic [MAG_W-1:0] OFS     = MAG_W'(OFFSET);

  cn_state_e         state_q, state_d;
  logic              run_q, run_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [MAG_W-1:0]  min1_q, min1_d, min2_q, min2_d;
  logic [IDX_W-1:0]  idx1_q, idx1_d;
  logic              sprod_q, sprod_d;
  logic [CN_DEG-1:0] sgn_q, sgn_d;
  logic              parity_q, parity_d;
  logic              pvalid_q, pvalid_d;

  logic              accept, c2v_hs, at_last;
  logic              in_sign;
  logic [MAG_W-1:0]  in_mag;
  logic [MAG_W-1:0]  upd_min1, upd_min2;
  logic [IDX_W-1:0]  upd_idx1;
  logic [MAG_W-1:0]  m_sel, m_off;
  logic              out_sign;

  assign in_sign = i_v2c[MSG_WIDTH-1];
  assign in_mag  = i_v2c[MAG_W-1:0];
  assign accept  = i_v2c_valid & o_v2c_ready;
  assign c2v_hs  = o_c2v_valid & i_c2v_ready;
  assign at_last = (cnt_q == LAST);

  cn_min2_update #(
    .MAG_W(MAG_W),
    .IDX_W(IDX_W)
  ) u_min2 (
    .i_min1(min1_q),
    .i_min2(min2_q),
    .i_idx1(idx1_q),
    .i_mag (in_mag),
    .i_idx (cnt_q),
    .o_min1(upd_min1),
    .o_min2(upd_min2),
    .o_idx1(upd_idx1)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_COLLECT;
      run_q    <= 1'b0;
      cnt_q    <= '0;
      min1_q   <= POS_MAX;
      min2_q   <= POS_MAX;
      idx1_q   <= '0;
      sprod_q  <= 1'b0;
      sgn_q    <= '0;
      parity_q <= 1'b0;
      pvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      min1_q   <= min1_d;
      min2_q   <= min2_d;
      idx1_q   <= idx1_d;
      sprod_q  <= sprod_d;
      sgn_q    <= sgn_d;
      parity_q <= parity_d;
      pvalid_q <= pvalid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (accept && at_last) state_d = ST_EMIT;
      ST_EMIT:    if (c2v_hs && at_last) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // The index counter is shared: it tracks input k in COLLECT and output j in EMIT.
  always_comb begin
    run_d    = 1'b1;
    cnt_d    = cnt_q;
    min1_d   = min1_q;
    min2_d   = min2_q;
    idx1_d   = idx1_q;
    sprod_d  = sprod_q;
    sgn_d    = sgn_q;
    parity_d = parity_q;
    pvalid_d = 1'b0;
    if (accept) begin
      cnt_d        = at_last ? '0 : cnt_q + IDX_W'(1);
      min1_d       = upd_min1;
      min2_d       = upd_min2;
      idx1_d       = upd_idx1;
      sgn_d[cnt_q] = in_sign;
      sprod_d      = sprod_q ^ in_sign;
      if (at_last) begin
        parity_d = sprod_q ^ in_sign;
        pvalid_d = 1'b1;
      end
    end
    if (c2v_hs) begin
      cnt_d = at_last ? '0 : cnt_q + IDX_W'(1);
      if (at_last) begin
        min1_d  = POS_MAX;
        min2_d  = POS_MAX;
        idx1_d  = '0;
        sprod_d = 1'b0;
      end
    end
  end

  always_comb begin
    o_v2c_ready    = run_q && (state_q == ST_COLLECT);
    o_c2v_valid    = (state_q == ST_EMIT);
    m_sel          = (cnt_q == idx1_q) ? min2_q : min1_q;
    m_off          = (m_sel > OFS) ? (m_sel - OFS) : '0;
    out_sign       = sprod_q ^ sgn_q[cnt_q];
    o_c2v          = '0;
    if (o_c2v_valid) begin
      o_c2v = MSG_WIDTH'(sm2tc(LDPC_MAX_W'({out_sign, m_off}), MSG_WIDTH));
    end
    o_parity       = parity_q;
    o_parity_valid = pvalid_q;
  end

endmodule

// File: tb/tb_cn_serial.sv
// Scoreboard bench for cn_serial at CN_DEG=4, MSG_WIDTH=6, OFFSET=1.
module tb_cn_serial;

  logic       clk;
  logic       i_rst;
  logic       i_v2c_valid;
  logic [5:0] i_v2c;
  logic       o_v2c_ready;
  logic       o_c2v_valid;
  logic [5:0] o_c2v;
  logic       i_c2v_ready;
  logic       o_parity;
  logic       o_parity_valid;

  int unsigned total;
  int unsigned bad;
  logic [5:0]  exp_q[$];

  cn_serial #(
    .MSG_WIDTH(6),
    .CN_DEG   (4),
    .OFFSET   (1)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_v2c_valid   (i_v2c_valid),
    .i_v2c         (i_v2c),
    .o_v2c_ready   (o_v2c_ready),
    .o_c2v_valid   (o_c2v_valid),
    .o_c2v         (o_c2v),
    .i_c2v_ready   (i_c2v_ready),
    .o_parity      (o_parity),
    .o_parity_valid(o_parity_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: each output is the minimum and sign product over all other inputs.
  function automatic logic [5:0] model_c2v(input logic [5:0] msgs [4], input int unsigned j);
    int unsigned m;
    logic        s;
    m = 31;
    s = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k != j) begin
        if (int'(msgs[k][4:0]) < int'(m)) m = msgs[k][4:0];
        s ^= msgs[k][5];
      end
    end
    m = (m > 1) ? m - 1 : 0;
    return s ? 6'(64 - m) : 6'(m);
  endfunction

  task automatic send_row(input logic [5:0] msgs [4], input logic [5:0] exp [4],
                          input int unsigned gap_max);
    logic        par;
    int unsigned n;
    par = 1'b0;
    exp_q.delete();
    for (int unsigned i = 0; i < 4; i++) begin
      exp_q.push_back(exp[i]);
      par ^= msgs[i][5];
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          i_v2c_valid = 1'b0;
          @(negedge clk);
        end
      end
      i_v2c_valid = 1'b1;
      i_v2c       = msgs[i];
      n = 0;
      while (o_v2c_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (o_v2c_ready !== 1'b1) begin
        bad++;
        $display("FAIL in_ready input %0d: got %b want 1", i, o_v2c_ready);
      end
      @(negedge clk);
    end
    i_v2c_valid = 1'b0;
    total++;
    if (o_parity_valid !== 1'b1 || o_parity !== par) begin
      bad++;
      $display("FAIL parity: got valid=%b parity=%b want valid=1 parity=%b",
               o_parity_valid, o_parity, par);
    end
    total++;
    if (o_c2v_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_c2v_latency: got valid=%b want 1", o_c2v_valid);
    end
  endtask

  task automatic drain(input int unsigned stall_at, input int unsigned stall_n, input logic junk);
    int unsigned got;
    int unsigned stalls;
    int unsigned budget;
    logic [5:0]  e;
    got    = 0;
    stalls = stall_n;
    budget = 0;
    while (got < 4 && budget < 60) begin
      budget++;
      if (got == stall_at && stalls > 0) begin
        i_c2v_ready = 1'b0;
        i_v2c_valid = junk;
        i_v2c       = 6'h01;
      end else begin
        i_c2v_ready = 1'b1;
        i_v2c_valid = 1'b0;
      end
      if (o_c2v_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL c2v_extra: got %h want no output", o_c2v);
        end else begin
          e = exp_q[0];
          if (o_c2v !== e) begin
            bad++;
            $display("FAIL c2v j=%0d: got %h want %h", got, o_c2v, e);
          end
          if (i_c2v_ready) begin
            void'(exp_q.pop_front());
            got++;
          end else begin
            stalls--;
            total++;
            if (o_v2c_ready !== 1'b0) begin
              bad++;
              $display("FAIL stall_in_ready: got %b want 0", o_v2c_ready);
            end
          end
        end
      end
      @(negedge clk);
    end
    i_c2v_ready = 1'b0;
    i_v2c_valid = 1'b0;
    total++;
    if (got != 4) begin
      bad++;
      $display("FAIL drain_count: got %0d outputs want 4", got);
    end
    total++;
    if (o_v2c_ready !== 1'b1 || o_c2v_valid !== 1'b0) begin
      bad++;
      $display("FAIL row_end: got ready=%b c2v_valid=%b want ready=1 c2v_valid=0",
               o_v2c_ready, o_c2v_valid);
    end
    total++;
    if (o_parity_valid !== 1'b0) begin
      bad++;
      $display("FAIL parity_pulse: got %b want 0", o_parity_valid);
    end
  endtask

  task automatic check_cleared(input string tag);
    total++;
    if (o_v2c_ready !== 1'b0 || o_c2v_valid !== 1'b0 || o_c2v !== 6'h00 ||
        o_parity !== 1'b0 || o_parity_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s: got ready=%b valid=%b c2v=%h par=%b pv=%b want all 0", tag,
               o_v2c_ready, o_c2v_valid, o_c2v, o_parity, o_parity_valid);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #2;
    check_cleared("reset_outputs");
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    total++;
    if (o_v2c_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: got %b want 0", o_v2c_ready);
    end
    @(negedge clk);
    total++;
    if (o_v2c_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_edge: got %b want 1", o_v2c_ready);
    end
  endtask

  task automatic test_mixed();
    logic [5:0] m[4];
    logic [5:0] e[4];
    m = '{6'h05, 6'h23, 6'h07, 6'h02};
    e = '{6'h3F, 6'h01, 6'h3F, 6'h3E};
    send_row(m, e, 0);
    drain(4, 0, 1'b0);
  endtask

  task automatic test_tie();
    logic [5:0] m[4];
    logic [5:0] e[4];
    m = '{6'h04, 6'h04, 6'h09, 6'h06};
    e = '{6'h03, 6'h03, 6'h03, 6'h03};
    send_row(m, e, 0);
    drain(4, 0, 1'b0);
  endtask

  task automatic test_floor();
    logic [5:0] m[4];
    logic [5:0] e[4];
    m = '{6'h01, 6'h00, 6'h21, 6'h05};
    e = '{6'h00, 6'h00, 6'h00, 6'h00};
    send_row(m, e, 0);
    drain(4, 0, 1'b0);
  endtask

  task automatic test_max();
    logic [5:0] m[4];
    logic [5:0] e[4];
    m = '{6'h1F, 6'h3F, 6'h1F, 6'h1F};
    e = '{6'h22, 6'h1E, 6'h22, 6'h22};
    send_row(m, e, 0);
    drain(4, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [5:0] m[4];
    logic [5:0] e[4];
    m = '{6'h05, 6'h23, 6'h07, 6'h02};
    e = '{6'h3F, 6'h01, 6'h3F, 6'h3E};
    send_row(m, e, 0);
    drain(1, 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [5:0] m[4];
    logic [5:0] e[4];
    i_v2c_valid = 1'b1;
    i_v2c       = 6'h1F;
    @(negedge clk);
    i_v2c       = 6'h00;
    @(negedge clk);
    i_v2c_valid = 1'b0;
    i_rst       = 1'b1;
    #1;
    check_cleared("reset_mid_outputs");
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    m = '{6'h05, 6'h23, 6'h07, 6'h02};
    e = '{6'h3F, 6'h01, 6'h3F, 6'h3E};
    send_row(m, e, 0);
    drain(4, 0, 1'b0);
  endtask

  task automatic test_random_gaps();
    logic [5:0] m[4];
    logic [5:0] e[4];
    for (int unsigned r = 0; r < 6; r++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        m[i][5]   = 1'($urandom_range(1, 0));
        m[i][4:0] = ($urandom_range(3, 0) == 0) ? 5'd3 : 5'($urandom_range(31, 0));
      end
      for (int unsigned j = 0; j < 4; j++) e[j] = model_c2v(m, j);
      send_row(m, e, 2);
      drain($urandom_range(3, 0), $urandom_range(2, 0), 1'b1);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    i_rst       = 1'b1;
    i_v2c_valid = 1'b0;
    i_v2c       = '0;
    i_c2v_ready = 1'b0;
    test_reset();
    test_mixed();
    test_tie();
    test_floor();
    test_max();
    test_reset_mid();
    test_backpressure();
    test_random_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
